// File: rtl/seg7_score_display_ctrl.sv
// ==========================================================================
// seg7_score_display_ctrl : score-to-BCD converter with 4-digit 7-seg refresh
// Revision 1.0 - initial release
// ==========================================================================
`default_nettype none

module seg7_score_display_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  SCORE,
  output logic [3:0]  SEG_SELECT,
  output logic [7:0]  HEX_OUT,
  output logic [11:0] BCD,
  output logic        BCD_VALID,
  output logic        BUSY
);

  localparam int                 c_PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_last_score;
  logic [7:0]          r_shift;
  logic [11:0]         r_bcd_work;
  logic [2:0]          r_iter;
  logic [c_PRE_W-1:0]  r_prescaler;
  logic [1:0]          r_idx;

  logic [11:0]         w_bcd_adj;
  logic                w_blank_h;
  logic                w_blank_t;
  logic [7:0]          w_digit_code;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign w_bcd_adj = {add3(r_bcd_work[11:8]), add3(r_bcd_work[7:4]), add3(r_bcd_work[3:0])};

  // Double-dabble converter; SCORE is only sampled in IDLE so the last value always wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_last_score <= 8'd0;
      r_shift      <= 8'd0;
      r_bcd_work   <= 12'd0;
      r_iter       <= 3'd0;
      BCD          <= 12'd0;
      BCD_VALID    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      BCD_VALID <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (SCORE != r_last_score) begin
            r_shift      <= SCORE;
            r_bcd_work   <= 12'd0;
            r_last_score <= SCORE;
            r_iter       <= 3'd0;
            BUSY         <= 1'b1;
            r_state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd_work, r_shift} <= {w_bcd_adj[10:0], r_shift, 1'b0};
          r_iter                <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= S_DONE;
        end
        S_DONE: begin
          BCD       <= r_bcd_work;
          BCD_VALID <= 1'b1;
          BUSY      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_blank_h = (BCD[11:8] == 4'd0);
  assign w_blank_t = w_blank_h && (BCD[7:4] == 4'd0);

  always_comb begin
    w_digit_code = 8'hFF;
    case (r_idx)
      2'd0:    w_digit_code = seg_decode(BCD[3:0]);
      2'd1:    w_digit_code = w_blank_t ? 8'hFF : seg_decode(BCD[7:4]);
      2'd2:    w_digit_code = w_blank_h ? 8'hFF : seg_decode(BCD[11:8]);
      default: w_digit_code = 8'hFF;
    endcase
  end

  // Anode and cathode are registered together so they always describe the same digit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prescaler <= '0;
      r_idx       <= 2'd0;
      SEG_SELECT  <= 4'b1110;
      HEX_OUT     <= 8'hC0;
    end else begin
      if (r_prescaler == c_PRE_MAX) begin
        r_prescaler <= '0;
        r_idx       <= r_idx + 2'd1;
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end
      SEG_SELECT <= ~(4'b0001 << r_idx);
      HEX_OUT    <= w_digit_code;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_score_display_ctrl.sv
// ==========================================================================
// tb_seg7_score_display_ctrl : directed vector bench for the score display
// Revision 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_seg7_score_display_ctrl;

  localparam int c_DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  SCORE;
  logic [3:0]  SEG_SELECT;
  logic [7:0]  HEX_OUT;
  logic [11:0] BCD;
  logic        BCD_VALID;
  logic        BUSY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  score;
    logic [11:0] bcd;
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [7:0]  h2;
  } vec_t;

  vec_t vecs [7];

  seg7_score_display_ctrl #(.REFRESH_DIV(c_DIV)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SCORE      (SCORE),
    .SEG_SELECT (SEG_SELECT),
    .HEX_OUT    (HEX_OUT),
    .BCD        (BCD),
    .BCD_VALID  (BCD_VALID),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!BCD_VALID && n < 30) begin
      tick();
      n++;
    end
  endtask

  // Watch two frames: every lit position must carry its expected code, and
  // positions must rotate 0,1,2,3 with each full run lasting c_DIV cycles.
  task automatic check_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_h [4];
    logic [7:0] act_h [4];
    int pos, prev, runlen, nruns, order_err;
    exp_h[0] = e0; exp_h[1] = e1; exp_h[2] = e2; exp_h[3] = e3;
    for (int p = 0; p < 4; p++) act_h[p] = 8'h00;
    prev = -1; runlen = 0; nruns = 0; order_err = 0;
    tick();
    for (int i = 0; i < 8 * c_DIV + 2; i++) begin
      case (SEG_SELECT)
        4'b1110: pos = 0;
        4'b1101: pos = 1;
        4'b1011: pos = 2;
        4'b0111: pos = 3;
        default: pos = -1;
      endcase
      if (pos < 0) begin
        order_err++;
      end else begin
        if (act_h[pos] === exp_h[pos] || act_h[pos] === 8'h00) act_h[pos] = HEX_OUT;
        if (pos == prev) begin
          runlen++;
        end else begin
          if (prev >= 0 && pos != (prev + 1) % 4) order_err++;
          if (nruns > 1 && runlen != c_DIV) order_err++;
          nruns++;
          runlen = 1;
          prev   = pos;
        end
      end
      tick();
    end
    for (int p = 0; p < 4; p++) chk($sformatf("%s_hex_pos%0d", nm, p), act_h[p], exp_h[p]);
    chk($sformatf("%s_scan_errs", nm), order_err, 0);
  endtask

  initial begin
    int n;
    int bad_valid;
    int saw200;

    vecs[0] = '{8'd7,   12'h007, 8'hF8, 8'hFF, 8'hFF};
    vecs[1] = '{8'd40,  12'h040, 8'hC0, 8'h99, 8'hFF};
    vecs[2] = '{8'd255, 12'h255, 8'h92, 8'h92, 8'hA4};
    vecs[3] = '{8'd100, 12'h100, 8'hC0, 8'hC0, 8'hF9};
    vecs[4] = '{8'd0,   12'h000, 8'hC0, 8'hFF, 8'hFF};
    vecs[5] = '{8'd9,   12'h009, 8'h90, 8'hFF, 8'hFF};
    vecs[6] = '{8'd58,  12'h058, 8'h80, 8'h92, 8'hFF};

    RESET = 1'b1;
    SCORE = 8'd0;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_seg",   SEG_SELECT, 4'b1110);
    chk("rst_hex",   HEX_OUT,    8'hC0);
    chk("rst_busy",  BUSY,       1'b0);
    chk("rst_bcd",   BCD,        12'h000);
    chk("rst_valid", BCD_VALID,  1'b0);

    bad_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (BCD_VALID !== 1'b0 || BUSY !== 1'b0) bad_valid++;
    end
    chk("idle_zero_quiet", bad_valid, 0);

    // 0 -> 123: cycle-exact BUSY / BCD_VALID profile
    SCORE = 8'd123;
    tick();
    chk("c123_busy_k", BUSY, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("c123_busy_k%0d", j),  BUSY,      (j <= 8) ? 1'b1 : 1'b0);
      chk($sformatf("c123_valid_k%0d", j), BCD_VALID, (j == 9) ? 1'b1 : 1'b0);
      if (j == 9) chk("c123_bcd", BCD, 12'h123);
    end
    check_frame("c123", 8'hB0, 8'hA4, 8'hF9, 8'hFF);

    for (int v = 0; v < 7; v++) begin
      SCORE = vecs[v].score;
      wait_valid(n);
      chk($sformatf("v%0d_latency", v), n, 10);
      chk($sformatf("v%0d_bcd", v), BCD, vecs[v].bcd);
      check_frame($sformatf("v%0d", v), vecs[v].h0, vecs[v].h1, vecs[v].h2, 8'hFF);
    end

    // 10 -> 200 -> 201 while converting: only the last value is picked up
    SCORE = 8'd10;
    tick();
    tick();
    tick();
    SCORE = 8'd200;
    tick();
    tick();
    SCORE = 8'd201;
    wait_valid(n);
    chk("chg_first_wait", n, 5);
    chk("chg_first_bcd",  BCD, 12'h010);
    tick();
    chk("chg_recapture_busy", BUSY, 1'b1);
    saw200 = 0;
    n = 0;
    while (!BCD_VALID && n < 30) begin
      tick();
      n++;
      if (BCD === 12'h200) saw200++;
    end
    chk("chg_second_wait", n, 9);
    chk("chg_final_bcd",   BCD, 12'h201);
    chk("chg_no_200",      saw200, 0);

    // Reset mid-conversion aborts and restarts from scratch
    for (int i = 0; i < 3; i++) tick();
    SCORE = 8'd99;
    tick();
    tick();
    tick();
    tick();
    RESET = 1'b1;
    tick();
    chk("abort_busy",  BUSY,       1'b0);
    chk("abort_bcd",   BCD,        12'h000);
    chk("abort_valid", BCD_VALID,  1'b0);
    chk("abort_seg",   SEG_SELECT, 4'b1110);
    chk("abort_hex",   HEX_OUT,    8'hC0);
    RESET = 1'b0;
    tick();
    chk("restart_busy", BUSY, 1'b1);
    wait_valid(n);
    chk("restart_wait", n, 9);
    chk("restart_bcd",  BCD, 12'h099);
    check_frame("restart", 8'h90, 8'h90, 8'hFF, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_score_display_ctrl.md
# seg7_score_display_ctrl

Sequences the four-digit common-anode seven-segment display that shows the snake game score. It converts the 8-bit binary score to BCD with a multi-cycle double-dabble engine, blanks leading zeros, and time-multiplexes the digits with its own refresh prescaler. It sits between the score register and the board's anode/cathode pins, and replaces ad-hoc strobe-driven digit selection.

## Interface
- REFRESH_DIV, 100000, CLK cycles each digit stays lit (100 MHz gives 1 kHz per digit).
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- SCORE  in  8  binary score, 0..255, may change on any cycle.
- SEG_SELECT  out  4  active-low anode enables; bit 0 is the rightmost digit.
- HEX_OUT  out  8  active-low cathodes {dp,g,f,e,d,c,b,a}; dp is always 1.
- BCD  out  12  {hundreds,tens,ones} of the last completed conversion.
- BCD_VALID  out  1  one-cycle pulse when BCD and the displayed digits update.
- BUSY  out  1  high while a conversion is in progress.

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If SCORE != last_score: load shift_reg <= SCORE, clear bcd_work, set last_score <= SCORE, clear iter, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**
  - Each cycle, add 3 to every nibble of bcd_work that is >= 5.
  - Then shift {bcd_work, shift_reg} left by 1 and increment iter.
  - After 8 shifts (iter == 7 on entry), go to DONE.
- **DONE**
  - Latch bcd_work into BCD and the digit registers.
  - Pulse BCD_VALID for one cycle and return to IDLE.
- SCORE changes during SHIFT or DONE are ignored. The mismatch with last_score is detected on return to IDLE, so the final value is always displayed.
- Leading-zero blanking, applied to the latched BCD:
  - Hundreds digit (position 2) is blank when hundreds == 0.
  - Tens digit (position 1) is blank when hundreds == 0 and tens == 0.
  - Ones digit (position 0) is always shown.
  - Position 3 is always blank (8'hFF).
- Refresh:
  - A prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On each wrap, digit index idx increments modulo 4.
  - SEG_SELECT = ~(4'b0001 << idx).
- Cathode decode, 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). Blank is FF.
- Reset values:
  - state IDLE, last_score 0, BCD 0, BCD_VALID 0, BUSY 0.
  - prescaler 0, idx 0.
  - SEG_SELECT 4'b1110, HEX_OUT 8'hC0, so the display reads "0".
- RESET during a conversion aborts it. State returns to reset values. If SCORE != 0 after reset, a new conversion starts in the first IDLE cycle.

## Timing
- Let edge k be the IDLE edge that captures a new SCORE.
- Edges k+1 through k+8 perform the 8 shifts. State is DONE after edge k+8.
- At edge k+9, BCD and the digit registers update and BCD_VALID is high for the cycle after edge k+9.
- Total latency from capture to BCD update is 9 cycles.
- BUSY is high from after edge k through the cycle after edge k+8, i.e. while in SHIFT or DONE.
- The earliest next capture is edge k+10.
- SEG_SELECT and HEX_OUT are registered together. Both change on the edge after idx changes, or after the digit registers update, so anode and cathode never mismatch.
- When idx wraps to 0 on the same edge that new digits latch, HEX_OUT shows the new ones digit on the following edge.
- Each digit is lit for exactly REFRESH_DIV cycles; one full frame is 4·REFRESH_DIV cycles.

## Test plan
- **Reset, SCORE=0:** no BCD_VALID pulse; SEG_SELECT=1110, HEX_OUT=C0; BUSY stays 0.
- **SCORE 0→123 at capture edge k:** BUSY high for 9 cycles; BCD_VALID pulses once after edge k+9; BCD=12'h123. With REFRESH_DIV=4, HEX_OUT cycles B0, A4, F9, FF across SEG_SELECT 1110, 1101, 1011, 0111 in steps of 4 cycles.
- **SCORE=7:** BCD=12'h007; positions 2 and 3 show FF, position 1 shows FF, position 0 shows F8. **SCORE=40:** tens shows 99, ones shows C0, hundreds shows FF.
- **SCORE=255:** BCD=12'h255, digits A4/92/92. **SCORE=100:** tens digit is not blanked (C0).
- **SCORE 10→200→201 at capture+3 and capture+5:** the first conversion completes with BCD=12'h010; the next capture (201) happens at edge k+10; the final BCD is 12'h201; no intermediate 200 is shown.
- **RESET asserted at capture+4 with SCORE=99:** BUSY drops and BCD=0 after the reset edge. After release, the conversion restarts and BCD=12'h099 nine cycles after the new capture edge.
